reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- 32-entry x 32-bit general-purpose register file, directly downstream of the writeback data select and destination-register select.
- Its single write port takes the selected writeback word and the selected destination index.
- Two combinational read ports feed the decode/execute stage.
- Writes are synchronous. Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of registers (must equal 2**ADDR_W)
- SP_IDX, 29, index of the stack-pointer register
- SP_RESET, 32'h0000_0FFC, reset value loaded into register SP_IDX

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe from control
- wr_addr  in  ADDR_W  destination index, from the destination-register select
- wr_data  in  DATA_W  writeback word, from the writeback data select
- rd_addr_a  in  ADDR_W  read port A index (rs)
- rd_addr_b  in  ADDR_W  read port B index (rt)
- rd_data_a  out  DATA_W  read port A data
- rd_data_b  out  DATA_W  read port B data
- dbg_addr  in  ADDR_W  debug read index
- dbg_data  out  DATA_W  debug read data; never bypassed
- wr_count  out  16  count of committed writes, excluding register 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0, except register SP_IDX, which loads SP_RESET.
  - wr_count clears to 0.
  - Reset takes effect immediately, regardless of clk; a write in flight is discarded.
- Release: the first write can commit on the first rising clk edge with rst_n high.
- Write, latency 1:
  - On a rising clk with wr_en=1 and wr_addr!=0, reg[wr_addr] takes wr_data.
  - wr_count increments by 1 and wraps from 16'hFFFF to 0.
- Register 0:
  - A write with wr_addr=0 is a no-op: no storage change, wr_count unchanged.
  - Any read of index 0 returns 0 on all ports, including the bypass path.
- Reads:
  - Purely combinational, latency 0.
  - rd_data_x = reg[rd_addr_x] as held before the current edge, unless bypass applies (see Optional Feature).
- dbg_data = reg[dbg_addr], combinational, always pre-edge storage.
- Simultaneous events:
  - A/B reading the same index as each other returns identical data.
  - Read and write of the same index in the same cycle are resolved per RF_BYPASS_EN.
- wr_en=X or wr_addr=X: out of contract; the bench must not drive it.
- There is no other state machine; the only sequential state is the register array and the write counter.

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined:
  - When wr_en=1 and wr_addr!=0 and rd_addr_x==wr_addr, rd_data_x = wr_data in the same cycle (write-first forwarding). This removes one writeback-to-decode hazard bubble.
  - Applies to ports A and B only.
- Undefined:
  - The read returns the old stored value (read-first). The new value is visible from the cycle after the edge.

Decomposition:
- Package rf_pkg holds:
  - DATA_W, ADDR_W
  - REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31
  - SP_RESET constant
  - typedef for the register index
- Sub-module rf_read_port:
  - Index into storage, zero-force for index 0, and, under RF_BYPASS_EN, bypass compare/select.
  - Instantiated twice, for A and B.
  - Debug port uses a plain index without bypass.

Test Plan:
- Reset with rst_n=0 mid-cycle, no clk edge:
  - rd_data for regs 1..31 reads 0, except reg 29, which reads 32'h0000_0FFC.
  - wr_count=0 immediately.
- Write then read:
  - wr_en=1, wr_addr=5, wr_data=32'hDEAD_BEEF, one edge.
  - rd_addr_a=5 gives DEAD_BEEF next cycle; wr_count=1.
- Register 0 write:
  - wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF.
  - rd_addr_a=0 reads 0 both before and after the edge; wr_count unchanged.
- Same-cycle read/write of reg 7 (old 32'h1, new 32'h2):
  - With RF_BYPASS_EN: rd_data_b=2 before the edge.
  - Without RF_BYPASS_EN: rd_data_b=1, then 2 after the edge.
  - dbg_data=1 in both builds.
- Reset during a write:
  - wr_en=1, wr_addr=31, wr_data=32'hA5A5_A5A5, with rst_n dropped before the edge.
  - reg 31 reads 0; wr_count=0.
- Counter wrap:
  - 65536 writes to reg 3 give wr_count=0.
  - Reg 3 holds the last written value.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the 32 x 32 writeback register file.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

  localparam logic [DATA_W-1:0] SP_RESET = 32'h0000_0FFC;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: index, zero-force for r0 and,
// when RF_BYPASS_EN is defined, write-first forwarding from the write port.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int D_W      = DATA_W,
  parameter int A_W      = ADDR_W,
  parameter int NUM_REGS = 32
) (
  input  logic [NUM_REGS-1:0][D_W-1:0] regs,
  input  logic [A_W-1:0]               addr,
`ifdef RF_BYPASS_EN
  input  logic                         wr_en,
  input  logic [A_W-1:0]               wr_addr,
  input  logic [D_W-1:0]               wr_data,
`endif
  output logic [D_W-1:0]               data
);

  // Index 0 must read zero even if a bypass would otherwise match it.
  always_comb begin
    data = regs[addr];
`ifdef RF_BYPASS_EN
    if (wr_en && (wr_addr != '0) && (wr_addr == addr)) begin
      data = wr_data;
    end
`endif
    if (addr == '0) begin
      data = '0;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32-entry register file fed by the writeback select; r0 reads as zero.
// Optional macro RF_BYPASS_EN enables write-first forwarding on ports A and B.
module reg_file_wb
  import rf_pkg::*;
#(
  parameter int                 DATA_W   = rf_pkg::DATA_W,
  parameter int                 ADDR_W   = rf_pkg::ADDR_W,
  parameter int                 NUM_REGS = 32,
  parameter int                 SP_IDX   = int'(REG_SP),
  parameter logic [DATA_W-1:0]  SP_RESET = rf_pkg::SP_RESET
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic                            commit;

  assign commit = wr_en && (wr_addr != '0);

  // Entry 0 is never written after reset, so its storage stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      wr_count <= '0;
    end else if (commit) begin
      regs_q[wr_addr] <= wr_data;
      wr_count        <= wr_count + 16'd1;
    end
  end

  rf_read_port #(.D_W(DATA_W), .A_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_port_a (
    .regs    (regs_q),
    .addr    (rd_addr_a),
`ifdef RF_BYPASS_EN
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .data    (rd_data_a)
  );

  rf_read_port #(.D_W(DATA_W), .A_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_port_b (
    .regs    (regs_q),
    .addr    (rd_addr_b),
`ifdef RF_BYPASS_EN
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .data    (rd_data_b)
  );

  // Debug view always shows committed storage, never the forwarded word.
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed corner cases plus random traffic
// checked against an array model of the register file.
module tb_reg_file_wb;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_regs [32];
  logic [15:0] model_count;

  reg_file_wb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_regs[29] = 32'h0000_0FFC;
    model_count = 16'h0;
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (we && wa != 5'd0 && a == wa) return wd;
`endif
    return model_regs[a];
  endfunction

  // One clock cycle: drive at the falling edge, check combinational outputs
  // just before the rising edge, then commit the write into the model.
  task automatic applyStimulus(input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] ra,
                               input logic [4:0] rb, input logic [4:0] da);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb; dbg_addr = da;
    #1;
    checkOutput("rd_a", rd_data_a, expRead(ra, we, wa, wd));
    checkOutput("rd_b", rd_data_b, expRead(rb, we, wa, wd));
    checkOutput("dbg", dbg_data, model_regs[da]);
    checkOutput("count", {16'h0, wr_count}, {16'h0, model_count});
    @(posedge clk);
    if (we && wa != 5'd0) begin
      model_regs[wa] = wd;
      model_count    = model_count + 16'd1;
    end
  endtask

  initial begin
    logic       we;
    logic [4:0] wa, ra;

    rst_n = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0; dbg_addr = 5'd0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_count", {16'h0, wr_count}, 32'h0);
    for (int i = 1; i < 32; i++) begin
      rd_addr_a = 5'(i);
      #1;
      checkOutput("reset_reg", rd_data_a, (i == 29) ? 32'h0000_0FFC : 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;

    // Write then read.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    checkOutput("wb_read", rd_data_a, 32'hDEAD_BEEF);
    checkOutput("wb_count", {16'h0, wr_count}, 32'h1);

    // Register 0 write is ignored.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    checkOutput("r0_read", rd_data_a, 32'h0);
    checkOutput("r0_count", {16'h0, wr_count}, 32'h1);

    // Same-cycle read/write of r7.
    applyStimulus(1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd7, 32'h2, 5'd7, 5'd7, 5'd7);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
    checkOutput("r7_after", rd_data_b, 32'h2);

    // Random traffic with frequent read/write index collisions.
    for (int n = 0; n < 300; n++) begin
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      ra = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = wa;
      applyStimulus(we, wa, $urandom, ra, 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
    end

    // Reset dropped while a write is pending.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5_A5A5;
    #2 rst_n = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    rd_addr_a = 5'd31; rd_addr_b = 5'd29; dbg_addr = 5'd5;
    #1;
    checkOutput("rstw_r31", rd_data_a, 32'h0);
    checkOutput("rstw_sp", rd_data_b, 32'h0000_0FFC);
    checkOutput("rstw_r5", dbg_data, 32'h0);
    checkOutput("rstw_count", {16'h0, wr_count}, 32'h0);
    wr_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Counter wrap after 65536 committed writes.
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'(i);
      @(posedge clk);
      model_regs[3] = 32'(i);
      model_count   = model_count + 16'd1;
      if (i == 65534) begin
        #1;
        checkOutput("wrap_pre", {16'h0, wr_count}, 32'h0000_FFFF);
      end
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
    checkOutput("wrap_count", {16'h0, wr_count}, 32'h0);
    checkOutput("wrap_r3", rd_data_a, 32'h0000_FFFF);

    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
